sysid_boot_checker: RTL and testbench

- Avalon-MM master sitting directly upstream of the system ID slave; it issues the two reads that slave serves (address 0 = system ID, address 1 = build timestamp) and compares results against values baked in at generation time.
- Produces sticky pass/fail flags and the captured words, for use by reset sequencing logic and LEDs before the soft processor boots.
- Runs once automatically after reset, or on demand via a start pulse.

---
 rtl/sysid_boot_checker.sv | 178 +++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker
//
// Avalon-MM master that reads the system ID slave before the soft processor
// boots: word 0 (system ID) and word 1 (build timestamp) are fetched once,
// captured, and compared against the values baked in at generation time.
// The results are held as sticky flags for reset sequencing and LEDs.
//
// Ports:
//   clock            system clock, rising-edge
//   reset            synchronous, active-high
//   start            one-cycle run request (ignored while busy)
//   avm_address      0 = ID word, 1 = timestamp word
//   avm_read         read strobe
//   avm_readdata     slave read data
//   avm_waitrequest  slave stall
//   busy             high from launch until done
//   done             sticky completion flag, cleared by the next launch
//   id_ok / ts_ok    captured word matched its expected value
//   timeout_err      a read stalled for TIMEOUT_CYCLES cycles
//   id_value         last captured ID word
//   ts_value         last captured timestamp word
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1687962169,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Last stalled count value that is still tolerated; the timeout fires in
  // the cycle the counter would reach TIMEOUT_CYCLES with the slave stalled.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  // Last latency-wait count; unused when READ_LATENCY is 0.
  localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic        auto_pend;
  logic [15:0] tmo_cnt;
  logic [1:0]  lat_cnt;

  logic in_rd;
  logic accept;
  logic stalled;
  logic tmo_hit;
  logic lat_last;
  logic launch;
  logic cap_id;
  logic cap_ts;

  assign in_rd    = (state == RD_ID) || (state == RD_TS);
  assign accept   = in_rd && !avm_waitrequest;
  assign stalled  = in_rd && avm_waitrequest;
  // Acceptance takes priority: tmo_hit only exists while still stalled.
  assign tmo_hit  = stalled && (tmo_cnt == TMO_LAST);
  assign lat_last = (lat_cnt == LAT_LAST);

  // auto_pend stands in for start on the first cycle out of reset.
  assign launch = ((state == IDLE) && (start || auto_pend)) ||
                  ((state == DONE) && start);

  assign cap_id = ((state == RD_ID) && accept && (READ_LATENCY == 0)) ||
                  ((state == LAT_ID) && lat_last);
  assign cap_ts = ((state == RD_TS) && accept && (READ_LATENCY == 0)) ||
                  ((state == LAT_TS) && lat_last);

  always_comb begin
    state_nxt   = state;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_nxt = RD_ID;
      end
      RD_ID: begin
        avm_read = 1'b1;
        busy     = 1'b1;
        if (accept)       state_nxt = (READ_LATENCY == 0) ? RD_TS : LAT_ID;
        else if (tmo_hit) state_nxt = DONE;
      end
      LAT_ID: begin
        busy = 1'b1;
        if (lat_last) state_nxt = RD_TS;
      end
      RD_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        busy        = 1'b1;
        if (accept)       state_nxt = (READ_LATENCY == 0) ? DONE : LAT_TS;
        else if (tmo_hit) state_nxt = DONE;
      end
      LAT_TS: begin
        avm_address = 1'b1;
        busy        = 1'b1;
        if (lat_last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (launch) state_nxt = RD_ID;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      auto_pend   <= AUTO_START;
      tmo_cnt     <= 16'd0;
      lat_cnt     <= 2'd0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
    end else begin
      state <= state_nxt;

      if (launch) auto_pend <= 1'b0;

      // Any state change restarts the stall count, so each RD_* state
      // starts from zero even when RD_ID hands straight to RD_TS.
      if (state_nxt != state) tmo_cnt <= 16'd0;
      else if (stalled)       tmo_cnt <= tmo_cnt + 16'd1;

      // The acceptance edge counts as the first latency cycle, so the
      // wait states capture on count READ_LATENCY-1.
      if ((state == LAT_ID) || (state == LAT_TS)) lat_cnt <= lat_cnt + 2'd1;
      else                                         lat_cnt <= 2'd0;

      if (launch) begin
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
      end

      // Compare against the bus word directly so the ok flag lands in the
      // same cycle as the captured value and is valid when done rises.
      if (cap_id) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
      end

      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Testbench for sysid_boot_checker.
// Three DUT copies with different parameters, each driven by a small
// Avalon slave model with programmable stall counts and read latency.
// Completions are checked by a scoreboard: the stimulus pushes the expected
// result (including the cycle done must rise), a monitor pops on each rising
// edge of done.
module tb_sysid_boot_checker;

  localparam logic [31:0] TS  = 32'h649C4239;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        rst_v[3];
  logic        start_v[3];
  logic [31:0] id_val[3];
  logic [31:0] ts_val[3];
  int          stall_id[3];
  int          stall_ts[3];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cyc;
    logic        iok;
    logic        tok;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int g, input int c, input logic iok, input logic tok,
                          input logic tmo, input logic [31:0] idv, input logic [31:0] tsv);
    exp_t e;
    e.cyc = c; e.iok = iok; e.tok = tok; e.tmo = tmo; e.idv = idv; e.tsv = tsv;
    case (g)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_done(input int g, input int c, input logic iok, input logic tok,
                            input logic tmo, input logic [31:0] idv, input logic [31:0] tsv);
    exp_t e;
    int   sz;
    case (g)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    n_tests++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL u%0d unexpected_done: done rose at cycle %0d, expected no completion", g, c);
    end else begin
      case (g)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("u%0d done_cycle", g), c, e.cyc);
      chk($sformatf("u%0d id_ok", g), iok, e.iok);
      chk($sformatf("u%0d ts_ok", g), tok, e.tok);
      chk($sformatf("u%0d timeout_err", g), tmo, e.tmo);
      chk($sformatf("u%0d id_value", g), idv, e.idv);
      chk($sformatf("u%0d ts_value", g), tsv, e.tsv);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 1) ? 2 : 0;
    localparam int TMO = (g == 2) ? 4 : 255;
    localparam bit AS  = (g == 0);

    logic        rd, addr, wr, busy, done, iok, tok, tmo;
    logic [31:0] rdata, idv, tsv, cur;
    int          stall_cnt = 0;
    int          rd_cnt = 0;
    logic        p1v, p2v;
    logic [31:0] p1d, p2d;
    logic        done_q, rd_q, wr_q, addr_q;

    sysid_boot_checker #(
      .READ_LATENCY  (LAT),
      .TIMEOUT_CYCLES(TMO),
      .AUTO_START    (AS)
    ) u_dut (
      .clock          (clock),
      .reset          (rst_v[g]),
      .start          (start_v[g]),
      .avm_address    (addr),
      .avm_read       (rd),
      .avm_readdata   (rdata),
      .avm_waitrequest(wr),
      .busy           (busy),
      .done           (done),
      .id_ok          (iok),
      .ts_ok          (tok),
      .timeout_err    (tmo),
      .id_value       (idv),
      .ts_value       (tsv)
    );

    // Slave model: stalls each read for a programmed count, then returns
    // data immediately (LAT=0) or LAT cycles after acceptance; any other
    // cycle shows a poison word so a mistimed capture is visible.
    always_comb begin
      cur = addr ? ts_val[g] : id_val[g];
      wr  = rd && (stall_cnt < (addr ? stall_ts[g] : stall_id[g]));
      if (LAT == 0) rdata = (rd && !wr) ? cur : BAD;
      else          rdata = p2v ? p2d : BAD;
    end

    always @(posedge clock) begin
      if (rst_v[g]) begin
        stall_cnt <= 0;
        p1v <= 1'b0;
        p2v <= 1'b0;
      end else begin
        stall_cnt <= (rd && wr) ? stall_cnt + 1 : 0;
        p1v <= rd && !wr;
        p2v <= p1v;
      end
      p1d <= cur;
      p2d <= p1d;
    end

    always @(negedge clock) begin
      if (done && !done_q) check_done(g, cyc, iok, tok, tmo, idv, tsv);
      if (rd) chk($sformatf("u%0d read_only_while_busy", g), busy, 1'b1);
      if (rd && rd_q && wr_q) chk($sformatf("u%0d address_held_in_stall", g), addr, addr_q);
      done_q <= done;
      rd_q   <= rd;
      wr_q   <= wr;
      addr_q <= addr;
      if (rd) rd_cnt <= rd_cnt + 1;
    end
  end

  function automatic logic [95:0] outs(input int g);
    logic [95:0] v;
    v = '0;
    case (g)
      0: v = {25'd0, g_inst[0].rd, g_inst[0].addr, g_inst[0].busy, g_inst[0].done,
              g_inst[0].iok, g_inst[0].tok, g_inst[0].tmo, g_inst[0].idv, g_inst[0].tsv};
      1: v = {25'd0, g_inst[1].rd, g_inst[1].addr, g_inst[1].busy, g_inst[1].done,
              g_inst[1].iok, g_inst[1].tok, g_inst[1].tmo, g_inst[1].idv, g_inst[1].tsv};
      default: v = {25'd0, g_inst[2].rd, g_inst[2].addr, g_inst[2].busy, g_inst[2].done,
              g_inst[2].iok, g_inst[2].tok, g_inst[2].tmo, g_inst[2].idv, g_inst[2].tsv};
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulse_start(input int g);
    start_v[g] = 1'b1;
    step();
    start_v[g] = 1'b0;
  endtask

  initial begin
    int l;
    int r;
    for (int g = 0; g < 3; g++) begin
      rst_v[g]    = 1'b1;
      start_v[g]  = 1'b0;
      id_val[g]   = 32'd0;
      ts_val[g]   = TS;
      stall_id[g] = 0;
      stall_ts[g] = 0;
    end
    repeat (3) step();
    for (int g = 0; g < 3; g++) chk($sformatf("u%0d reset_outputs", g), outs(g), 96'd0);

    // Auto-start after reset with a zero-latency, no-stall slave.
    l = cyc;
    for (int g = 0; g < 3; g++) rst_v[g] = 1'b0;
    push_exp(0, l + 3, 1'b1, 1'b1, 1'b0, 32'd0, TS);
    step();
    chk("u0 id_read_cycle", {g_inst[0].rd, g_inst[0].addr}, 2'b10);
    step();
    chk("u0 ts_read_cycle", {g_inst[0].rd, g_inst[0].addr}, 2'b11);
    step();
    chk("u0 read_released", g_inst[0].rd, 1'b0);
    repeat (3) step();
    chk("u1 no_read_without_start", g_inst[1].rd_cnt, 0);
    chk("u2 no_read_without_start", g_inst[2].rd_cnt, 0);

    // Wrong ID word, relaunched from DONE.
    id_val[0] = 32'h0000_0001;
    l = cyc;
    push_exp(0, l + 3, 1'b0, 1'b1, 1'b0, 32'h0000_0001, TS);
    pulse_start(0);
    wait_to(l + 6);
    id_val[0] = 32'd0;

    // Latency 2 with five stall cycles on each read.
    stall_id[1] = 5;
    stall_ts[1] = 5;
    r = g_inst[1].rd_cnt;
    l = cyc;
    push_exp(1, l + 17, 1'b1, 1'b1, 1'b0, 32'd0, TS);
    pulse_start(1);
    wait_to(l + 20);
    chk("u1 read_strobe_cycles", g_inst[1].rd_cnt - r, 12);

    // Stuck waitrequest with TIMEOUT_CYCLES=4; a start while busy is ignored.
    stall_id[2] = 1000;
    r = g_inst[2].rd_cnt;
    l = cyc;
    push_exp(2, l + 5, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    pulse_start(2);
    step();
    pulse_start(2);
    wait_to(l + 8);
    chk("u2 stalled_read_cycles", g_inst[2].rd_cnt - r, 4);
    chk("u2 flags_held_in_done", {g_inst[2].done, g_inst[2].tmo, g_inst[2].busy}, 3'b110);

    // Restart from DONE clears the flags; two runs with identical timing.
    stall_id[2] = 0;
    l = cyc;
    push_exp(2, l + 3, 1'b1, 1'b1, 1'b0, 32'd0, TS);
    pulse_start(2);
    chk("u2 flags_cleared_on_launch", {g_inst[2].done, g_inst[2].tmo, g_inst[2].busy}, 3'b001);
    wait_to(l + 5);
    l = cyc;
    push_exp(2, l + 3, 1'b1, 1'b1, 1'b0, 32'd0, TS);
    pulse_start(2);
    wait_to(l + 6);

    // Reset while stalled in the timestamp read aborts, then auto-relaunches.
    stall_ts[0] = 1000;
    l = cyc;
    pulse_start(0);
    wait_to(l + 5);
    chk("u0 stalled_in_ts_read", {g_inst[0].rd, g_inst[0].addr, g_inst[0].busy}, 3'b111);
    rst_v[0] = 1'b1;
    step();
    chk("u0 reset_abort_outputs", outs(0), 96'd0);
    rst_v[0]    = 1'b0;
    stall_ts[0] = 0;
    l = cyc;
    push_exp(0, l + 3, 1'b1, 1'b1, 1'b0, 32'd0, TS);
    wait_to(l + 6);

    repeat (2) step();
    chk("u0 pending_completions", q0.size(), 0);
    chk("u1 pending_completions", q1.size(), 0);
    chk("u2 pending_completions", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
